// File: rtl/display_scan_if.sv
// Handshake and decoder-side signals of the 7-segment scan controller.
// The master modport is the controlling side; the slave modport is the scan controller itself.
interface display_scan_if #(
  parameter int NUM_DIG = 4
);
  logic                 enable;
  logic [4*NUM_DIG-1:0] datos;
  logic                 cargar;
  logic                 cargar_ack;
  logic                 lamp_test;
  logic                 supr_ceros;
  logic [3:0]           Entradas;
  logic [1:0]           LT_BI;
  logic                 LE;
  logic [NUM_DIG-1:0]   anodos;
  logic                 fin_cuadro;

  modport master (
    output enable, datos, cargar, lamp_test, supr_ceros,
    input  cargar_ack, Entradas, LT_BI, LE, anodos, fin_cuadro
  );

  modport slave (
    input  enable, datos, cargar, lamp_test, supr_ceros,
    output cargar_ack, Entradas, LT_BI, LE, anodos, fin_cuadro
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for NUM_DIG common-anode 7-segment digits sharing one
// decoder; a double-buffered value is committed only on frame boundaries.
//
//   state | meaning
//   IDLE  | scan stopped, all digits dark
//   BLANK | anti-ghosting gap, decoder input settles for digit idx
//   SHOW  | digit idx driven, decoder latched
module display_scan_ctrl #(
  parameter int NUM_DIG   = 4,
  parameter int PRESC     = 1000,
  parameter int BLANK_CYC = 16
) (
  input logic           clk,
  input logic           rst_n,
  display_scan_if.slave bus
);

  localparam int DW = 4 * NUM_DIG;
  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int IW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESC - 1);
  localparam logic [PW-1:0] B_LAST = PW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIG - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      presc, presc_nxt;
  logic [IW-1:0]      idx, idx_nxt;
  logic [DW-1:0]      disp, disp_nxt, hold;
  logic               pending, lamp_flag, lamp_nxt;
  logic               frame_end, commit;
  logic [NUM_DIG-1:0] supr, an_nxt;
  logic               zero_above;
  logic [3:0]         dig_nxt;
  logic [1:0]         ltbi_nxt;

  assign frame_end = bus.enable && (state == SHOW) && (presc == P_LAST) && (idx == I_LAST);
  assign commit    = frame_end && pending;
  assign disp_nxt  = commit ? hold : disp;
  assign lamp_nxt  = frame_end ? bus.lamp_test : lamp_flag;

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    idx_nxt   = idx;
    if (!bus.enable) begin
      state_nxt = IDLE;
      presc_nxt = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          presc_nxt = '0;
          idx_nxt   = '0;
        end
        BLANK: begin
          presc_nxt = presc + PW'(1);
          if (presc == B_LAST) state_nxt = SHOW;
        end
        SHOW: begin
          if (presc == P_LAST) begin
            presc_nxt = '0;
            state_nxt = BLANK;
            idx_nxt   = (idx == I_LAST) ? '0 : idx + IW'(1);
          end else begin
            presc_nxt = presc + PW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A digit is suppressed when it and every more significant digit are zero; digit 0 never is.
  always_comb begin
    zero_above = 1'b1;
    supr       = '0;
    for (int k = NUM_DIG - 1; k > 0; k--) begin
      zero_above = zero_above && (disp_nxt[4*k +: 4] == 4'd0);
      supr[k]    = zero_above;
    end
  end

  always_comb begin
    dig_nxt         = disp_nxt[{idx_nxt, 2'b00} +: 4];
    an_nxt          = '1;
    an_nxt[idx_nxt] = 1'b0;
    if (state_nxt != SHOW)
      ltbi_nxt = 2'b10;
    else if (lamp_nxt)
      ltbi_nxt = 2'b00;
    else if ((bus.supr_ceros && supr[idx_nxt]) || (dig_nxt > 4'd9))
      ltbi_nxt = 2'b10;
    else
      ltbi_nxt = 2'b11;
  end

  // Outputs are registered from next-state values so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      presc          <= '0;
      idx            <= '0;
      disp           <= '0;
      hold           <= '0;
      pending        <= 1'b0;
      lamp_flag      <= 1'b0;
      bus.Entradas   <= 4'd0;
      bus.LT_BI      <= 2'b10;
      bus.LE         <= 1'b0;
      bus.anodos     <= '1;
      bus.cargar_ack <= 1'b0;
      bus.fin_cuadro <= 1'b0;
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      idx       <= idx_nxt;
      disp      <= disp_nxt;
      lamp_flag <= lamp_nxt;
      if (bus.cargar) hold <= bus.datos;
      pending        <= bus.cargar || (pending && !commit);
      bus.cargar_ack <= commit;
      bus.fin_cuadro <= (state_nxt == SHOW) && (presc_nxt == P_LAST) && (idx_nxt == I_LAST);
      bus.Entradas   <= (state_nxt == IDLE) ? 4'd0 : dig_nxt;
      bus.LT_BI      <= ltbi_nxt;
      bus.LE         <= (state_nxt == SHOW);
      bus.anodos     <= (state_nxt == SHOW) ? an_nxt : '1;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl with NUM_DIG=4, PRESC=8, BLANK_CYC=2 (32-cycle frames).
module tb_display_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  display_scan_if #(.NUM_DIG(4)) bus ();

  display_scan_ctrl #(.NUM_DIG(4), .PRESC(8), .BLANK_CYC(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] ent;
    logic [1:0] ltbi;
    logic       le;
    logic [3:0] an;
    logic       fin;
    logic       ack;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic exp_t sample();
    exp_t a;
    a.ent  = bus.Entradas;
    a.ltbi = bus.LT_BI;
    a.le   = bus.LE;
    a.an   = bus.anodos;
    a.fin  = bus.fin_cuadro;
    a.ack  = bus.cargar_ack;
    return a;
  endfunction

  function automatic exp_t idle_vec();
    exp_t e;
    e.ent = 4'd0; e.ltbi = 2'b10; e.le = 1'b0; e.an = 4'hF; e.fin = 1'b0; e.ack = 1'b0;
    return e;
  endfunction

  // lt holds the SHOW-phase LT_BI per digit, digit 0 in bits [1:0]
  task automatic push_frame(input logic [15:0] d, input logic [7:0] lt, input logic ack0);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < 8; p++) begin
        e.ent = d[4*i +: 4];
        e.fin = (i == 3 && p == 7);
        e.ack = ack0 && (i == 0) && (p == 0);
        if (p < 2) begin
          e.ltbi = 2'b10; e.le = 1'b0; e.an = 4'hF;
        end else begin
          e.ltbi = lt[2*i +: 2]; e.le = 1'b1; e.an = 4'hF; e.an[i] = 1'b0;
        end
        sb.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    exp_t a, e;
    bus.enable = 1'b0; bus.datos = '0; bus.cargar = 1'b0; bus.lamp_test = 1'b0; bus.supr_ceros = 1'b0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) rst_n = 1'b1;
      sb.push_back(idle_vec());
      e = sb.pop_front(); a = sample(); vectors++;
      if (a !== e) begin miscompares++; $display("FAIL reset c%0d: got %p, expected %p", c, a, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_basic();
    exp_t a, e;
    bus.enable = 1'b1; bus.cargar = 1'b1; bus.datos = 16'h1234;
    @(negedge clk);
    bus.cargar = 1'b0;
    push_frame(16'h0000, 8'hFF, 1'b0);
    push_frame(16'h1234, 8'hFF, 1'b1);
    for (int c = 0; c < 64; c++) begin
      if (sb.size() == 0) begin miscompares++; $display("FAIL basic c%0d: scoreboard empty", c); end
      else begin
        e = sb.pop_front(); a = sample(); vectors++;
        if (a !== e) begin miscompares++; $display("FAIL basic c%0d: got %p, expected %p", c, a, e); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_supr();
    exp_t a, e;
    push_frame(16'h1234, 8'hFF, 1'b0);
    push_frame(16'h0070, 8'hAF, 1'b1);
    push_frame(16'h0070, 8'hFF, 1'b0);
    for (int c = 0; c < 96; c++) begin
      if (c == 0) begin bus.supr_ceros = 1'b1; bus.cargar = 1'b1; bus.datos = 16'h0070; end
      if (c == 1) bus.cargar = 1'b0;
      if (c == 64) bus.supr_ceros = 1'b0;
      if (sb.size() == 0) begin miscompares++; $display("FAIL supr c%0d: scoreboard empty", c); end
      else begin
        e = sb.pop_front(); a = sample(); vectors++;
        if (a !== e) begin miscompares++; $display("FAIL supr c%0d: got %p, expected %p", c, a, e); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lamp();
    exp_t a, e;
    push_frame(16'h0070, 8'hFF, 1'b0);
    push_frame(16'h0070, 8'h00, 1'b0);
    push_frame(16'h0070, 8'hFF, 1'b0);
    for (int c = 0; c < 96; c++) begin
      if (c == 10) bus.lamp_test = 1'b1;
      if (c == 32) bus.lamp_test = 1'b0;
      if (sb.size() == 0) begin miscompares++; $display("FAIL lamp c%0d: scoreboard empty", c); end
      else begin
        e = sb.pop_front(); a = sample(); vectors++;
        if (a !== e) begin miscompares++; $display("FAIL lamp c%0d: got %p, expected %p", c, a, e); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    exp_t a, e;
    push_frame(16'h0070, 8'hFF, 1'b0);
    push_frame(16'h2222, 8'hFF, 1'b1);
    push_frame(16'h3333, 8'hFF, 1'b1);
    for (int c = 0; c < 96; c++) begin
      if (c == 3)  begin bus.cargar = 1'b1; bus.datos = 16'h1111; end
      if (c == 10) begin bus.cargar = 1'b1; bus.datos = 16'h2222; end
      if (c == 31) begin bus.cargar = 1'b1; bus.datos = 16'h3333; end
      if (c == 4 || c == 11 || c == 32) bus.cargar = 1'b0;
      if (sb.size() == 0) begin miscompares++; $display("FAIL b2b c%0d: scoreboard empty", c); end
      else begin
        e = sb.pop_front(); a = sample(); vectors++;
        if (a !== e) begin miscompares++; $display("FAIL b2b c%0d: got %p, expected %p", c, a, e); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_code_over_nine();
    exp_t a, e;
    push_frame(16'h3333, 8'hFF, 1'b0);
    push_frame(16'h12A4, 8'hFB, 1'b1);
    for (int c = 0; c < 64; c++) begin
      if (c == 0) begin bus.cargar = 1'b1; bus.datos = 16'h12A4; end
      if (c == 1) bus.cargar = 1'b0;
      if (sb.size() == 0) begin miscompares++; $display("FAIL hexdig c%0d: scoreboard empty", c); end
      else begin
        e = sb.pop_front(); a = sample(); vectors++;
        if (a !== e) begin miscompares++; $display("FAIL hexdig c%0d: got %p, expected %p", c, a, e); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_enable_drop();
    exp_t a, e;
    push_frame(16'h12A4, 8'hFB, 1'b0);
    while (sb.size() > 21) void'(sb.pop_back());
    repeat (3) sb.push_back(idle_vec());
    push_frame(16'h12A4, 8'hFB, 1'b0);
    for (int c = 0; c < 56; c++) begin
      if (c == 20) bus.enable = 1'b0;
      if (c == 23) bus.enable = 1'b1;
      if (sb.size() == 0) begin miscompares++; $display("FAIL endrop c%0d: scoreboard empty", c); end
      else begin
        e = sb.pop_front(); a = sample(); vectors++;
        if (a !== e) begin miscompares++; $display("FAIL endrop c%0d: got %p, expected %p", c, a, e); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    exp_t a, e;
    push_frame(16'h12A4, 8'hFB, 1'b0);
    while (sb.size() > 6) void'(sb.pop_back());
    for (int c = 0; c < 6; c++) begin
      e = sb.pop_front(); a = sample(); vectors++;
      if (a !== e) begin miscompares++; $display("FAIL rstmid pre c%0d: got %p, expected %p", c, a, e); end
      if (c < 5) @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    e = idle_vec(); a = sample(); vectors++;
    if (a !== e) begin miscompares++; $display("FAIL rstmid async: got %p, expected %p", a, e); end
    bus.enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.enable = 1'b1;
    @(negedge clk);
    push_frame(16'h0000, 8'hFF, 1'b0);
    for (int c = 0; c < 32; c++) begin
      if (sb.size() == 0) begin miscompares++; $display("FAIL rstmid c%0d: scoreboard empty", c); end
      else begin
        e = sb.pop_front(); a = sample(); vectors++;
        if (a !== e) begin miscompares++; $display("FAIL rstmid c%0d: got %p, expected %p", c, a, e); end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_supr();
    test_lamp();
    test_back_to_back();
    test_code_over_nine();
    test_enable_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexed scan controller for a bank of NUM_DIG common-anode 7-segment digits sharing one Display_7_Seg decoder.
- Sequences the decoder inputs (Entradas, LT_BI, LE) and the per-digit anode enables.
- Double-buffers the displayed value with a load handshake so commits occur only on frame boundaries.
- Provides leading-zero suppression, frame-stable lamp test and an anti-ghosting blank interval.

Parameters:
- NUM_DIG, 4, number of multiplexed digits (≥2).
- PRESC, 1000, clock cycles per digit slot (blank + show).
- BLANK_CYC, 16, blank cycles at the start of each slot; must satisfy 1 ≤ BLANK_CYC < PRESC.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  scan enable; low forces IDLE.
- datos  in  4*NUM_DIG  packed BCD value; digit 0 (least significant, rightmost) is in bits [3:0].
- cargar  in  1  load request; samples datos.
- cargar_ack  out  1  one-cycle pulse when the captured value is committed to the display.
- lamp_test  in  1  active-high lamp-test request.
- supr_ceros  in  1  leading-zero suppression enable.
- Entradas  out  4  BCD code to the decoder.
- LT_BI  out  2  decoder control: 2'b11 normal, 2'b10 blank, 2'b00 lamp test.
- LE  out  1  decoder latch enable: 0 transparent, 1 latched.
- anodos  out  NUM_DIG  active-low digit enables.
- fin_cuadro  out  1  one-cycle pulse on the last cycle of each frame.

Behaviour:
- Clocking and reset
  - All outputs are registered.
  - Reset values: Entradas=0, LT_BI=2'b10, LE=0, anodos all 1, cargar_ack=0, fin_cuadro=0.
  - Internal reset values: display register 0, hold register 0, pending=0, idx=0, prescaler=0, state IDLE.
- FSM
  - IDLE: anodos all 1, LT_BI=10, LE=0. When enable=1, go to BLANK with idx=0 and prescaler=0.
  - BLANK: lasts BLANK_CYC cycles. anodos all 1, LT_BI=10, LE=0, Entradas=disp[idx]. Then go to SHOW.
  - SHOW: lasts PRESC-BLANK_CYC cycles. anodos[idx]=0, all other anodos 1, LE=1.
    - LT_BI=00 if the frame lamp-test flag is set.
    - Otherwise LT_BI=10 if the digit is suppressed or the code is >9.
    - Otherwise LT_BI=11.
  - End of SHOW: idx increments. After NUM_DIG-1, idx wraps to 0 (frame end), then return to BLANK.
  - enable=0 in any state: IDLE on the next edge; idx and prescaler cleared; pending and hold preserved.
  - rst_n low mid-operation: immediate asynchronous return to reset values.
- Frame boundary
  - The last SHOW cycle of idx=NUM_DIG-1 asserts fin_cuadro.
  - On that same edge:
    - lamp_test is sampled into the frame flag.
    - If pending=1: disp←hold, pending←0, cargar_ack=1 on the next cycle.
  - lamp_test changes mid-frame have no effect until the next frame.
- Load handshake
  - cargar=1 at an edge: hold←datos, pending←1.
  - Repeated cargar before the commit: the last value wins; only one cargar_ack is issued.
  - cargar on the same edge as a commit: the old hold is committed, the new datos is captured, pending stays 1, and the next frame commits it.
  - cargar while IDLE: captured; committed at the first frame end after enable.
- Zero suppression (supr_ceros=1)
  - A digit k>0 is suppressed iff disp[k]==0 and every disp[j]==0 for j>k.
  - Digit 0 is never suppressed.
  - Evaluated on the committed display register only.

Test Plan:
1. NUM_DIG=4, PRESC=8, BLANK_CYC=2; reset, enable=1, cargar one cycle with datos=16'h1234 → cargar_ack one cycle after the first fin_cuadro (frame=32 cycles). Next frame, per slot: 2 cycles anodos=1111/LT_BI=10, then 6 cycles of digit/anodos pairs 4/1110, 3/1101, 2/1011, 1/0111 with LT_BI=11 and LE=1.
2. datos=16'h0070, supr_ceros=1 → digits 3 and 2 SHOW with LT_BI=10, digit 1 Entradas=7/LT_BI=11, digit 0 Entradas=0/LT_BI=11. With supr_ceros=0, all four slots show LT_BI=11.
3. lamp_test raised mid-frame → the current frame is unchanged. The next frame has LT_BI=00 in every SHOW slot, and LT_BI=10 in every BLANK.
4. cargar 16'h1111 then 16'h2222 in the same frame → a single cargar_ack, display shows 2222. cargar 16'h3333 on the commit edge → the 2222 frame is shown, then 3333 is committed at the next frame end with a second ack.
5. enable dropped during digit 2 SHOW → next cycle anodos=1111, LT_BI=10, LE=0. Re-enable → BLANK for digit 0. rst_n pulsed low mid-SHOW → outputs go to reset values without a clock edge.
6. disp digit value 4'hA → its SHOW slot drives LT_BI=10 (blank); other digits are unaffected.
